// File: rtl/sprite_path_pkg.sv
// Shared types and table field layout for the sprite path mover.
// Field offsets are functions of the coordinate widths so every user agrees on one layout.
package sprite_path_pkg;

  localparam logic [1:0] DirDownRight = 2'd0;  // x+1, y+1
  localparam logic [1:0] DirDownLeft  = 2'd1;  // x-1, y+1
  localparam logic [1:0] DirUpRight   = 2'd2;  // x+1, y-1
  localparam logic [1:0] DirUpLeft    = 2'd3;  // x-1, y-1

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StScan,
    StErase,
    StUpdate,
    StDraw
  } state_e;

  // Segment entry {valid, slope, c[xw:0], x_lo, x_hi}, LSB-aligned.
  function automatic int unsigned seg_w(input int unsigned xw);
    return 3 * xw + 3;
  endfunction

  function automatic int unsigned seg_lo_lsb(input int unsigned xw);
    return xw;
  endfunction

  function automatic int unsigned seg_c_lsb(input int unsigned xw);
    return 2 * xw;
  endfunction

  function automatic int unsigned seg_slope_bit(input int unsigned xw);
    return 3 * xw + 1;
  endfunction

  function automatic int unsigned seg_valid_bit(input int unsigned xw);
    return 3 * xw + 2;
  endfunction

  // Portal entry {valid, trig_x, trig_y, dst_x, dst_y}, LSB-aligned.
  function automatic int unsigned port_w(input int unsigned xw, input int unsigned yw);
    return 2 * (xw + yw) + 1;
  endfunction

  function automatic int unsigned port_dx_lsb(input int unsigned yw);
    return yw;
  endfunction

  function automatic int unsigned port_ty_lsb(input int unsigned xw, input int unsigned yw);
    return xw + yw;
  endfunction

  function automatic int unsigned port_tx_lsb(input int unsigned xw, input int unsigned yw);
    return xw + 2 * yw;
  endfunction

  function automatic int unsigned port_valid_bit(input int unsigned xw, input int unsigned yw);
    return 2 * (xw + yw);
  endfunction

endpackage

// File: rtl/sprite_move_tick.sv
// Free-running move-rate divider: pulses tick_o for one cycle every TICK_DIV clocks.
module sprite_move_tick #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_path_mover.sv
// Diagonal sprite mover: validates each step against loadable walkway/portal tables,
// then sequences the drawer through erase-background and draw-character.
module sprite_path_mover
  import sprite_path_pkg::*;
#(
  parameter int unsigned X_W        = 9,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned NUM_SEG    = 8,
  parameter int unsigned NUM_PORTAL = 2,
  parameter int unsigned TICK_DIV   = 6250000,
  parameter int unsigned START_X    = 95,
  parameter int unsigned START_Y    = 221,
  localparam int unsigned MaxN  = (NUM_SEG > NUM_PORTAL) ? NUM_SEG : NUM_PORTAL,
  localparam int unsigned AW    = (MaxN > 1) ? $clog2(MaxN) : 1,
  localparam int unsigned CFG_W = (seg_w(X_W) > port_w(X_W, Y_W)) ? seg_w(X_W)
                                                                   : port_w(X_W, Y_W)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             move,
  input  logic [1:0]       dir,
  input  logic             doneBG,
  input  logic             doneChar,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [X_W-1:0]   xCoordinate,
  output logic [Y_W-1:0]   yCoordinate,
  output logic             drawBG,
  output logic             drawChar,
  output logic             busy,
  output logic             moveOk,
  output logic             moveBlocked,
  output logic             teleported
);

  localparam int unsigned SegW    = seg_w(X_W);
  localparam int unsigned PortW   = port_w(X_W, Y_W);
  localparam int unsigned SegLo   = seg_lo_lsb(X_W);
  localparam int unsigned SegC    = seg_c_lsb(X_W);
  localparam int unsigned SegSlp  = seg_slope_bit(X_W);
  localparam int unsigned SegVld  = seg_valid_bit(X_W);
  localparam int unsigned PortDx  = port_dx_lsb(Y_W);
  localparam int unsigned PortTy  = port_ty_lsb(X_W, Y_W);
  localparam int unsigned PortTx  = port_tx_lsb(X_W, Y_W);
  localparam int unsigned PortVld = port_valid_bit(X_W, Y_W);
  localparam int unsigned NScan   = NUM_PORTAL + NUM_SEG;
  localparam int unsigned IW      = (NScan > 1) ? $clog2(NScan) : 1;
  localparam int unsigned SW      = X_W + 2;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, nx_q, nx_d, dst_x_q, dst_x_d;
  logic [Y_W-1:0] y_q, y_d, ny_q, ny_d, dst_y_q, dst_y_d;
  logic           tele_q, tele_d;
  logic           blocked_q, blocked_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [SegW-1:0]  seg_q  [NUM_SEG];
  logic [PortW-1:0] port_q [NUM_PORTAL];

  logic tick;

  sprite_move_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (clock),
    .rst_ni(resetn),
    .tick_o(tick)
  );

  assign busy        = (state_q != StIdle);
  assign drawBG      = (state_q == StErase);
  assign drawChar    = (state_q == StDraw);
  assign moveOk      = (state_q == StUpdate);
  assign teleported  = moveOk & tele_q;
  assign moveBlocked = blocked_q;
  assign xCoordinate = x_q;
  assign yCoordinate = y_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SEG; i++) seg_q[i] <= '0;
      for (int i = 0; i < NUM_PORTAL; i++) port_q[i] <= '0;
    end else if (cfg_we && !busy) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (!cfg_sel && cfg_addr == AW'(i)) seg_q[i] <= cfg_data[SegW-1:0];
      end
      for (int i = 0; i < NUM_PORTAL; i++) begin
        if (cfg_sel && cfg_addr == AW'(i)) port_q[i] <= cfg_data[PortW-1:0];
      end
    end
  end

  // Candidate carries one extra bit so wrap below 0 or past 2^W-1 shows up in the MSB.
  logic [X_W:0] cand_x;
  logic [Y_W:0] cand_y;
  logic         cand_off;

  always_comb begin
    cand_x = {1'b0, x_q} + 1'b1;
    cand_y = {1'b0, y_q} + 1'b1;
    unique case (dir)
      DirDownRight: begin
        cand_x = {1'b0, x_q} + 1'b1;
        cand_y = {1'b0, y_q} + 1'b1;
      end
      DirDownLeft: begin
        cand_x = {1'b0, x_q} - 1'b1;
        cand_y = {1'b0, y_q} + 1'b1;
      end
      DirUpRight: begin
        cand_x = {1'b0, x_q} + 1'b1;
        cand_y = {1'b0, y_q} - 1'b1;
      end
      DirUpLeft: begin
        cand_x = {1'b0, x_q} - 1'b1;
        cand_y = {1'b0, y_q} - 1'b1;
      end
      default: ;
    endcase
    cand_off = cand_x[X_W] | cand_y[Y_W] | (cand_x == '0) | (cand_y == '0);
  end

  // Scan index walks portals first, then segments.
  logic [PortW-1:0]     cur_port;
  logic [SegW-1:0]      cur_seg;
  logic                 in_portals, port_hit, seg_hit;
  logic signed [SW-1:0] nx_s, ny_s, c_s, line_y;

  always_comb begin
    cur_port = '0;
    cur_seg  = '0;
    for (int i = 0; i < NUM_PORTAL; i++) begin
      if (idx_q == IW'(i)) cur_port = port_q[i];
    end
    for (int i = 0; i < NUM_SEG; i++) begin
      if (idx_q == IW'(NUM_PORTAL + i)) cur_seg = seg_q[i];
    end
    in_portals = (idx_q < IW'(NUM_PORTAL));

    port_hit = cur_port[PortVld] && (cur_port[PortTx +: X_W] == nx_q)
               && (cur_port[PortTy +: Y_W] == ny_q);

    nx_s   = SW'(nx_q);
    ny_s   = SW'(ny_q);
    c_s    = SW'(cur_seg[SegC +: X_W + 1]);
    line_y = cur_seg[SegSlp] ? (nx_s - c_s) : (c_s - nx_s);
    seg_hit = cur_seg[SegVld] && (ny_s == line_y)
              && (cur_seg[SegLo +: X_W] <= nx_q) && (nx_q <= cur_seg[X_W-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    tele_d    = tele_q;
    idx_d     = idx_q;
    blocked_d = 1'b0;
    unique case (state_q)
      StInit: state_d = StDraw;
      StIdle: begin
        if (move && tick) begin
          nx_d   = cand_x[X_W-1:0];
          ny_d   = cand_y[Y_W-1:0];
          tele_d = 1'b0;
          idx_d  = '0;
          if (cand_off) begin
            blocked_d = 1'b1;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (in_portals && port_hit) begin
          tele_d  = 1'b1;
          dst_x_d = cur_port[PortDx +: X_W];
          dst_y_d = cur_port[Y_W-1:0];
          state_d = StErase;
        end else if (!in_portals && seg_hit) begin
          state_d = StErase;
        end else if (idx_q == IW'(NScan - 1)) begin
          blocked_d = 1'b1;
          state_d   = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StErase: begin
        if (doneBG) state_d = StUpdate;
      end
      StUpdate: begin
        x_d     = tele_q ? dst_x_q : nx_q;
        y_d     = tele_q ? dst_y_q : ny_q;
        state_d = StDraw;
      end
      StDraw: begin
        if (doneChar) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StInit;
      x_q       <= X_W'(START_X);
      y_q       <= Y_W'(START_Y);
      nx_q      <= '0;
      ny_q      <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      tele_q    <= 1'b0;
      blocked_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
      tele_q    <= tele_d;
      blocked_q <= blocked_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_sprite_path_mover.sv
// Directed bench for sprite_path_mover: walkway, portal, off-screen, tick-rate and reset cases.
module tb_sprite_path_mover;

  localparam logic [34:0] Seg0  = {5'd0, 1'b1, 1'b0, 10'd316, 9'd95, 9'd120};
  localparam logic [34:0] Port0 = {1'b1, 9'd120, 8'd196, 9'd126, 8'd68};
  localparam logic [34:0] Seg1  = {5'd0, 1'b1, 1'b1, 10'd58, 9'd127, 9'd127};
  localparam logic [34:0] Seg2  = {5'd0, 1'b1, 1'b0, 10'd194, 9'd0, 9'd319};

  logic        clock = 1'b0;
  logic        resetn, move, move2, doneBG, doneChar, cfg_we, cfg_sel;
  logic [1:0]  dir, dir2;
  logic [2:0]  cfg_addr;
  logic [34:0] cfg_data;
  logic [8:0]  x, x2;
  logic [7:0]  y, y2;
  logic        drawBG, drawChar, busy, moveOk, moveBlocked, teleported;
  logic        drawBG2, drawChar2, busy2, moveOk2, moveBlocked2, teleported2;

  always #5 clock = ~clock;

  sprite_path_mover #(
    .TICK_DIV(32)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .move       (move),
    .dir        (dir),
    .doneBG     (doneBG),
    .doneChar   (doneChar),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .xCoordinate(x),
    .yCoordinate(y),
    .drawBG     (drawBG),
    .drawChar   (drawChar),
    .busy       (busy),
    .moveOk     (moveOk),
    .moveBlocked(moveBlocked),
    .teleported (teleported)
  );

  sprite_path_mover #(
    .TICK_DIV(32),
    .START_X (1),
    .START_Y (1)
  ) dut_corner (
    .clock      (clock),
    .resetn     (resetn),
    .move       (move2),
    .dir        (dir2),
    .doneBG     (doneBG),
    .doneChar   (doneChar),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .xCoordinate(x2),
    .yCoordinate(y2),
    .drawBG     (drawBG2),
    .drawChar   (drawChar2),
    .busy       (busy2),
    .moveOk     (moveOk2),
    .moveBlocked(moveBlocked2),
    .teleported (teleported2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic [34:0] data);
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    cfg_we   = 1'b1;
    @(negedge clock);
    cfg_we   = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the IDLE exit; -1 means the event never happened.
  task automatic run_move(input logic [1:0] d, output int ok_c, output int bl_c,
                          output int tp_c, output int bg_n, output int ok_x);
    bit hit, fin;
    int c;
    ok_c = -1; bl_c = -1; tp_c = -1; bg_n = 0; ok_x = -1;
    hit = 1'b0; fin = 1'b0;
    dir  = d;
    move = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clock);
      hit = busy | moveBlocked;
    end
    move = 1'b0;
    check("move_start", hit, 1);
    if (!hit) return;
    c = 1;
    for (int k = 0; k < 60; k++) begin
      if (moveOk && ok_c < 0) begin
        ok_c = c;
        ok_x = x;
      end
      if (moveBlocked && bl_c < 0) bl_c = c;
      if (teleported && tp_c < 0) tp_c = c;
      if (drawBG) bg_n++;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      @(negedge clock);
      c++;
    end
    check("move_end", fin, 1);
  endtask

  int okc, blc, tpc, bgn, okx, steps, nok;
  bit hit, seen, wrote;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; move = 1'b0; move2 = 1'b0; dir = 2'd0; dir2 = 2'd0;
    doneBG = 1'b1; doneChar = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clock);
    check("rst_x", x, 95);
    check("rst_y", y, 221);
    check("rst_busy", busy, 1);
    check("rst_drawBG", drawBG, 0);
    check("rst_drawChar", drawChar, 0);
    check("rst_moveOk", moveOk, 0);
    check("rst_blocked", moveBlocked, 0);
    check("rst_teleported", teleported, 0);

    resetn = 1'b1;
    @(negedge clock);
    check("init_draw", drawChar, 1);
    check("init_busy", busy, 1);
    doneChar = 1'b1;
    @(negedge clock);
    check("init_idle", busy, 0);

    cfg_write(1'b0, 3'd0, Seg0);
    cfg_write(1'b1, 3'd0, Port0);

    // Segment 0 is the third scanned entry.
    run_move(2'd2, okc, blc, tpc, bgn, okx);
    check("a_ok_cycle", okc, 5);
    check("a_old_x_at_ok", okx, 95);
    check("a_erase_cycles", bgn, 1);
    check("a_no_block", blc, -1);
    check("a_x", x, 96);
    check("a_y", y, 220);

    run_move(2'd0, okc, blc, tpc, bgn, okx);
    check("b_block_cycle", blc, 11);
    check("b_no_erase", bgn, 0);
    check("b_no_ok", okc, -1);
    check("b_x", x, 96);
    check("b_y", y, 220);

    // Three tick periods with move held high; a table write attempted while busy.
    dir = 2'd2; move = 1'b1; nok = 0; wrote = 1'b0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clock);
      cfg_we = 1'b0;
      if (moveOk) nok++;
      if (busy && !wrote) begin
        cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_data = '0; cfg_we = 1'b1;
        wrote = 1'b1;
      end
    end
    move = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (moveOk) nok++;
    end
    check("c_steps", nok, 3);
    check("c_x", x, 99);
    check("c_y", y, 217);

    steps = 0;
    for (int s = 0; s < 20; s++) begin
      run_move(2'd2, okc, blc, tpc, bgn, okx);
      if (okc == 5) steps++;
    end
    check("walk_steps", steps, 20);
    check("walk_x", x, 119);
    check("walk_y", y, 197);

    run_move(2'd2, okc, blc, tpc, bgn, okx);
    check("tp_ok_cycle", okc, 3);
    check("tp_pulse_cycle", tpc, 3);
    check("tp_x", x, 126);
    check("tp_y", y, 68);

    cfg_write(1'b0, 3'd1, Seg1);
    run_move(2'd0, okc, blc, tpc, bgn, okx);
    check("s1_ok_cycle", okc, 6);
    check("s1_no_tp", tpc, -1);
    check("s1_x", x, 127);
    check("s1_y", y, 69);

    run_move(2'd0, okc, blc, tpc, bgn, okx);
    check("s1_past_hi_block", blc, 11);
    check("s1_past_hi_x", x, 127);

    move2 = 1'b1; dir2 = 2'd3; hit = 1'b0; seen = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clock);
      seen = seen | busy2;
      hit  = moveBlocked2;
    end
    move2 = 1'b0;
    check("off_blocked", hit, 1);
    check("off_no_scan", seen, 0);
    check("off_x", x2, 1);
    check("off_y", y2, 1);

    cfg_write(1'b0, 3'd2, Seg2);
    doneBG = 1'b0; dir = 2'd3; move = 1'b1; hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clock);
      hit = drawBG;
    end
    move = 1'b0;
    check("erase_reached", hit, 1);
    repeat (2) @(negedge clock);
    check("erase_hold", drawBG, 1);
    check("erase_old_x", x, 127);
    check("erase_old_y", y, 69);
    resetn = 1'b0;
    #1;
    check("rst2_drawBG", drawBG, 0);
    check("rst2_x", x, 95);
    check("rst2_y", y, 221);
    check("rst2_busy", busy, 1);
    check("rst2_drawChar", drawChar, 0);
    doneBG = 1'b1; doneChar = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("rst2_init_draw", drawChar, 1);
    doneChar = 1'b1;
    @(negedge clock);
    check("rst2_idle", busy, 0);

    run_move(2'd2, okc, blc, tpc, bgn, okx);
    check("cleared_block", blc, 11);
    check("cleared_no_ok", okc, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
